// File: rtl/time_counter_pkg.sv
// Shared constants and helpers for the cascaded time counter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package time_counter_pkg;

  localparam int unsigned DEFAULT_STAGE_W    = 8;
  localparam int unsigned DEFAULT_NUM_STAGES = 3;

  // Stage 0 occupies the least significant 32 bits: seconds, minutes, then a 0..99 hour field.
  localparam logic [DEFAULT_NUM_STAGES*32-1:0] DEFAULT_MODS = {32'd100, 32'd60, 32'd60};

  // Saturate a preset value into the legal range 0..modulus-1 of a stage.
  function automatic logic [31:0] clamp_to_mod(input logic [31:0] val, input logic [31:0] modulus);
    return (val >= modulus) ? (modulus - 32'd1) : val;
  endfunction

endpackage

// File: rtl/mod_counter_stage.sv
// One modulo-MOD up/down counter stage with clamped preset and terminal/wrap flags.
// Latency: value updates one cycle after a step/load/clear edge; terminal and wrap are combinational.
// Backpressure: none; step is accepted every cycle it is high.
module mod_counter_stage
  import time_counter_pkg::*;
#(
  parameter int unsigned STAGE_W = DEFAULT_STAGE_W,
  parameter int unsigned MOD     = 60
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               load,
  input  logic [STAGE_W-1:0] load_val,
  input  logic               step,
  input  logic               up_dn,
  output logic [STAGE_W-1:0] value,
  output logic               terminal,
  output logic               wrap
);

  // A modulus outside 2..2**STAGE_W cannot be represented by this stage.
  if ((MOD < 2) || (64'(MOD) > (64'd1 << STAGE_W))) begin : g_bad_mod
    $error("mod_counter_stage: MOD must lie in 2..2**STAGE_W");
  end

  localparam logic [STAGE_W-1:0] MAX_VAL = STAGE_W'(MOD - 1);
  localparam logic [STAGE_W-1:0] ONE     = STAGE_W'(1);

  logic [STAGE_W-1:0] load_clamped;

  assign load_clamped = STAGE_W'(clamp_to_mod(32'(load_val), 32'(MOD)));

  // Terminal depends on direction: the value from which the next step rolls over.
  assign terminal = up_dn ? (value == MAX_VAL) : (value == '0);
  assign wrap     = step & terminal;

  // Stage register: reset > clear > load > step.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      value <= '0;
    end else if (clear) begin
      value <= '0;
    end else if (load) begin
      value <= load_clamped;
    end else if (step) begin
      if (up_dn) begin
        value <= terminal ? '0 : (value + ONE);
      end else begin
        value <= terminal ? MAX_VAL : (value - ONE);
      end
    end
  end

endmodule

// File: rtl/time_counter_chain.sv
// Cascaded mixed-radix up/down time counter with preset, lap capture and full-wrap pulse.
// Latency: count/display/lap_active/wrap are registered (one cycle after the edge); zero is combinational from count.
// Backpressure: none; tick is consumed every cycle it is high (ignored only when halted at zero).
module time_counter_chain
  import time_counter_pkg::*;
#(
  parameter int unsigned                  NUM_STAGES   = DEFAULT_NUM_STAGES,
  parameter int unsigned                  STAGE_W      = DEFAULT_STAGE_W,
  parameter logic [NUM_STAGES*32-1:0]     MODS         = DEFAULT_MODS,
  parameter bit                           STOP_AT_ZERO = 1'b0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          tick,
  input  logic                          clear,
  input  logic                          up_dn,
  input  logic                          load,
  input  logic [NUM_STAGES*STAGE_W-1:0] load_val,
  input  logic                          lap,
  input  logic                          lap_release,
  output logic [NUM_STAGES*STAGE_W-1:0] count,
  output logic [NUM_STAGES*STAGE_W-1:0] display,
  output logic                          wrap,
  output logic                          zero,
  output logic                          lap_active
);

  logic [STAGE_W-1:0] stage_val  [NUM_STAGES];
  logic               stage_term [NUM_STAGES];
  logic               stage_wrap [NUM_STAGES];
  logic               step_en    [NUM_STAGES];

  logic                          tick_eff;
  logic                          carry_run;
  logic                          full_wrap;
  logic [NUM_STAGES*STAGE_W-1:0] lap_q;

  // A down-count parked at all-zero swallows the tick when halting is enabled.
  assign tick_eff = tick & ~(STOP_AT_ZERO & ~up_dn & zero);

  // Ripple the carry/borrow: stage i steps only when every lower stage is terminal.
  always_comb begin
    carry_run = tick_eff;
    for (int i = 0; i < NUM_STAGES; i++) begin
      step_en[i] = carry_run;
      carry_run  = carry_run & stage_term[i];
    end
  end

  for (genvar i = 0; i < NUM_STAGES; i++) begin : g_stage
    mod_counter_stage #(
      .STAGE_W (STAGE_W),
      .MOD     (MODS[32*i +: 32])
    ) u_stage (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear    (clear),
      .load     (load),
      .load_val (load_val[i*STAGE_W +: STAGE_W]),
      .step     (step_en[i]),
      .up_dn    (up_dn),
      .value    (stage_val[i]),
      .terminal (stage_term[i]),
      .wrap     (stage_wrap[i])
    );
  end

  // Pack the stage registers into the flat count bus, stage 0 in the LSBs.
  always_comb begin
    count = '0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      count[i*STAGE_W +: STAGE_W] = stage_val[i];
    end
  end

  // The chain wraps only when every stage rolls over on the same tick.
  always_comb begin
    full_wrap = 1'b1;
    for (int i = 0; i < NUM_STAGES; i++) begin
      full_wrap = full_wrap & stage_wrap[i];
    end
  end

  assign zero    = (count == '0);
  assign display = lap_active ? lap_q : count;

  // Wrap pulse: a wrapping tick that loses to clear or load produces no pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wrap <= 1'b0;
    end else begin
      wrap <= full_wrap & ~clear & ~load;
    end
  end

  // Lap capture: clear wipes it, lap (re)captures the pre-edge count, release drops the hold.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lap_q      <= '0;
      lap_active <= 1'b0;
    end else if (clear) begin
      lap_q      <= '0;
      lap_active <= 1'b0;
    end else if (lap) begin
      lap_q      <= count;
      lap_active <= 1'b1;
    end else if (lap_release) begin
      lap_active <= 1'b0;
    end
  end

endmodule

// File: tb/tb_time_counter_chain.sv
// Self-checking bench: directed vector table, hand-written corner sequences, randomized traffic.
// Two instances (wrapping and halting at zero) share stimulus; a mixed-radix integer model predicts both.
// All checks sample #1 after the active edge.
module tb_time_counter_chain;

  localparam int W = 24;
  localparam int unsigned M0 = 60;
  localparam int unsigned M1 = 60;
  localparam int unsigned M2 = 100;
  localparam int unsigned P  = M0 * M1 * M2;

  typedef struct {
    logic         rst_n;
    logic         clear;
    logic         load;
    logic [W-1:0] load_val;
    logic         tick;
    logic         up_dn;
    logic         lap;
    logic         lap_release;
  } in_t;

  typedef struct {
    in_t          in;
    logic [W-1:0] exp_count;
    logic         exp_wrap;
    logic         exp_la;
    logic [W-1:0] exp_disp;
  } vec_t;

  logic         clk;
  logic         rst_n, tick, clear, up_dn, load, lap, lap_release;
  logic [W-1:0] load_val;
  logic [W-1:0] count0, count1, display0, display1;
  logic         wrap0, wrap1, zero0, zero1, la0, la1;

  int checks;
  int failures;

  // Reference model state, index 0 = wrapping instance, 1 = halting instance.
  int unsigned m_cnt [2];
  int unsigned m_lap [2];
  bit          m_la  [2];
  bit          m_wrap[2];

  time_counter_chain #(
    .NUM_STAGES(3), .STAGE_W(8), .MODS({32'd100, 32'd60, 32'd60}), .STOP_AT_ZERO(1'b0)
  ) u_dut0 (
    .clk(clk), .rst_n(rst_n), .tick(tick), .clear(clear), .up_dn(up_dn), .load(load),
    .load_val(load_val), .lap(lap), .lap_release(lap_release), .count(count0),
    .display(display0), .wrap(wrap0), .zero(zero0), .lap_active(la0)
  );

  time_counter_chain #(
    .NUM_STAGES(3), .STAGE_W(8), .MODS({32'd100, 32'd60, 32'd60}), .STOP_AT_ZERO(1'b1)
  ) u_dut1 (
    .clk(clk), .rst_n(rst_n), .tick(tick), .clear(clear), .up_dn(up_dn), .load(load),
    .load_val(load_val), .lap(lap), .lap_release(lap_release), .count(count1),
    .display(display1), .wrap(wrap1), .zero(zero1), .lap_active(la1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [W-1:0] digits(input int unsigned v);
    logic [W-1:0] d;
    int unsigned  r;
    r        = v;
    d[7:0]   = 8'(r % M0);
    r        = r / M0;
    d[15:8]  = 8'(r % M1);
    r        = r / M1;
    d[23:16] = 8'(r);
    return d;
  endfunction

  function automatic int unsigned from_load(input logic [W-1:0] lv);
    int unsigned f0, f1, f2;
    f0 = 32'(lv[7:0]);
    f1 = 32'(lv[15:8]);
    f2 = 32'(lv[23:16]);
    if (f0 >= M0) f0 = M0 - 1;
    if (f1 >= M1) f1 = M1 - 1;
    if (f2 >= M2) f2 = M2 - 1;
    return f2 * M1 * M0 + f1 * M0 + f0;
  endfunction

  function automatic in_t mk_in(input bit r, input bit clr, input bit ld, input logic [W-1:0] lv,
                                input bit tk, input bit ud, input bit lp, input bit rel);
    in_t v;
    v.rst_n = r; v.clear = clr; v.load = ld; v.load_val = lv;
    v.tick = tk; v.up_dn = ud; v.lap = lp; v.lap_release = rel;
    return v;
  endfunction

  function automatic vec_t mk_vec(input in_t i, input logic [W-1:0] ec, input bit ew,
                                  input bit ela, input logic [W-1:0] ed);
    vec_t t;
    t.in = i; t.exp_count = ec; t.exp_wrap = ew; t.exp_la = ela; t.exp_disp = ed;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Model of one clock edge, expressed on the whole count as one integer in 0..P-1.
  task automatic model_edge(input in_t v);
    for (int k = 0; k < 2; k++) begin
      int unsigned pre;
      pre = m_cnt[k];
      if (!v.rst_n || v.clear) begin
        m_cnt[k] = 0; m_lap[k] = 0; m_la[k] = 1'b0; m_wrap[k] = 1'b0;
      end else begin
        m_wrap[k] = 1'b0;
        if (v.load) begin
          m_cnt[k] = from_load(v.load_val);
        end else if (v.tick) begin
          if (v.up_dn) begin
            m_cnt[k]  = (pre + 1) % P;
            m_wrap[k] = (m_cnt[k] == 0);
          end else if (!(k == 1 && pre == 0)) begin
            m_cnt[k]  = (pre + P - 1) % P;
            m_wrap[k] = (pre == 0);
          end
        end
        if (v.lap) begin
          m_lap[k] = pre; m_la[k] = 1'b1;
        end else if (v.lap_release) begin
          m_la[k] = 1'b0;
        end
      end
    end
  endtask

  task automatic check_model();
    for (int k = 0; k < 2; k++) begin
      logic [W-1:0] c, d, ed;
      logic         w, z, a;
      c = (k == 1) ? count1   : count0;
      d = (k == 1) ? display1 : display0;
      w = (k == 1) ? wrap1    : wrap0;
      z = (k == 1) ? zero1    : zero0;
      a = (k == 1) ? la1      : la0;
      ed = m_la[k] ? digits(m_lap[k]) : digits(m_cnt[k]);
      check($sformatf("model_count%0d", k),   32'(c), 32'(digits(m_cnt[k])));
      check($sformatf("model_display%0d", k), 32'(d), 32'(ed));
      check($sformatf("model_wrap%0d", k),    32'(w), 32'(m_wrap[k]));
      check($sformatf("model_zero%0d", k),    32'(z), 32'(m_cnt[k] == 0));
      check($sformatf("model_lap_active%0d", k), 32'(a), 32'(m_la[k]));
    end
  endtask

  task automatic apply(input in_t v);
    rst_n = v.rst_n; clear = v.clear; load = v.load; load_val = v.load_val;
    tick = v.tick; up_dn = v.up_dn; lap = v.lap; lap_release = v.lap_release;
    @(posedge clk);
    model_edge(v);
    #1;
    check_model();
  endtask

  vec_t tbl[$];
  in_t  idle, up1, dn1;
  bit   any_wrap;

  initial begin
    checks = 0; failures = 0;
    for (int k = 0; k < 2; k++) begin
      m_cnt[k] = 0; m_lap[k] = 0; m_la[k] = 1'b0; m_wrap[k] = 1'b0;
    end
    rst_n = 1'b0; clear = 1'b0; load = 1'b0; load_val = '0;
    tick = 1'b0; up_dn = 1'b1; lap = 1'b0; lap_release = 1'b0;

    idle = mk_in(1, 0, 0, 24'h0, 0, 1, 0, 0);
    up1  = mk_in(1, 0, 0, 24'h0, 1, 1, 0, 0);
    dn1  = mk_in(1, 0, 0, 24'h0, 1, 0, 0, 0);

    // Reset state.
    apply(mk_in(0, 0, 0, 24'h0, 1, 1, 1, 0));
    apply(mk_in(0, 0, 0, 24'h0, 0, 1, 0, 0));
    check("rst_count",   32'(count0),   32'h0);
    check("rst_display", 32'(display0), 32'h0);
    check("rst_zero",    32'(zero0),    32'h1);
    check("rst_wrap",    32'(wrap0),    32'h0);
    check("rst_lap",     32'(la0),      32'h0);

    // 3600 up ticks from zero: one full minute field rollover into stage 2, no chain wrap.
    any_wrap = 1'b0;
    for (int i = 0; i < 3600; i++) begin
      apply(up1);
      any_wrap = any_wrap | wrap0;
    end
    check("up3600_count", 32'(count0), 32'h010000);
    check("up3600_nowrap", 32'(any_wrap), 32'h0);
    apply(mk_in(1, 1, 0, 24'h0, 0, 1, 0, 0));

    // Directed table for the wrapping instance, {stage2,stage1,stage0} in hex bytes.
    tbl.push_back(mk_vec(mk_in(1,0,1,24'h633B3A,0,1,0,0), 24'h633B3A, 0, 0, 24'h633B3A));
    tbl.push_back(mk_vec(up1,                              24'h633B3B, 0, 0, 24'h633B3B));
    tbl.push_back(mk_vec(up1,                              24'h000000, 1, 0, 24'h000000));
    tbl.push_back(mk_vec(idle,                             24'h000000, 0, 0, 24'h000000));
    tbl.push_back(mk_vec(dn1,                              24'h633B3B, 1, 0, 24'h633B3B));
    tbl.push_back(mk_vec(mk_in(1,0,1,24'h00000A,0,1,0,0), 24'h00000A, 0, 0, 24'h00000A));
    tbl.push_back(mk_vec(mk_in(1,0,0,24'h0,0,1,1,0),      24'h00000A, 0, 1, 24'h00000A));
    tbl.push_back(mk_vec(up1,                              24'h00000B, 0, 1, 24'h00000A));
    tbl.push_back(mk_vec(up1,                              24'h00000C, 0, 1, 24'h00000A));
    tbl.push_back(mk_vec(up1,                              24'h00000D, 0, 1, 24'h00000A));
    tbl.push_back(mk_vec(up1,                              24'h00000E, 0, 1, 24'h00000A));
    tbl.push_back(mk_vec(up1,                              24'h00000F, 0, 1, 24'h00000A));
    tbl.push_back(mk_vec(mk_in(1,0,0,24'h0,0,1,0,1),      24'h00000F, 0, 0, 24'h00000F));
    tbl.push_back(mk_vec(mk_in(1,0,0,24'h0,0,1,1,1),      24'h00000F, 0, 1, 24'h00000F));
    tbl.push_back(mk_vec(up1,                              24'h000010, 0, 1, 24'h00000F));
    tbl.push_back(mk_vec(mk_in(1,0,1,24'h00004B,0,1,0,0), 24'h00003B, 0, 1, 24'h00000F));
    tbl.push_back(mk_vec(mk_in(1,0,1,24'hC8463C,0,1,0,0), 24'h633B3B, 0, 1, 24'h00000F));
    tbl.push_back(mk_vec(mk_in(1,0,1,24'h010203,1,1,0,0), 24'h010203, 0, 1, 24'h00000F));
    tbl.push_back(mk_vec(mk_in(1,0,1,24'h633B3B,0,1,0,0), 24'h633B3B, 0, 1, 24'h00000F));
    tbl.push_back(mk_vec(mk_in(1,1,1,24'h010203,1,1,0,0), 24'h000000, 0, 0, 24'h000000));
    tbl.push_back(mk_vec(mk_in(1,0,1,24'h633B3B,0,1,0,0), 24'h633B3B, 0, 0, 24'h633B3B));
    tbl.push_back(mk_vec(mk_in(1,1,0,24'h0,1,1,0,0),      24'h000000, 0, 0, 24'h000000));

    foreach (tbl[i]) begin
      apply(tbl[i].in);
      check($sformatf("tbl%0d_count", i),   32'(count0),   32'(tbl[i].exp_count));
      check($sformatf("tbl%0d_wrap", i),    32'(wrap0),    32'(tbl[i].exp_wrap));
      check($sformatf("tbl%0d_lap", i),     32'(la0),      32'(tbl[i].exp_la));
      check($sformatf("tbl%0d_display", i), 32'(display0), 32'(tbl[i].exp_disp));
    end

    // Down from zero: the wrapping instance rolls to all-max, the halting one holds.
    apply(mk_in(1, 1, 0, 24'h0, 0, 1, 0, 0));
    apply(dn1);
    check("dn0_wrap_count", 32'(count0), 32'h633B3B);
    check("dn0_wrap_pulse", 32'(wrap0),  32'h1);
    check("dn0_stop_count", 32'(count1), 32'h0);
    check("dn0_stop_wrap",  32'(wrap1),  32'h0);
    apply(dn1);
    check("dn0_stop_hold2", 32'(count1), 32'h0);
    check("dn0_wrap_once",  32'(wrap0),  32'h0);
    apply(up1);
    check("stop_up_count",  32'(count1), 32'h1);

    // Reset on the same edge as a wrapping tick while lap is active.
    apply(mk_in(1, 0, 1, 24'h633B3B, 0, 1, 0, 0));
    apply(mk_in(1, 0, 0, 24'h0, 0, 1, 1, 0));
    check("pre_rst_lap", 32'(la0), 32'h1);
    apply(mk_in(0, 0, 0, 24'h0, 1, 1, 1, 0));
    check("mid_rst_count",   32'(count0),   32'h0);
    check("mid_rst_display", 32'(display0), 32'h0);
    check("mid_rst_wrap",    32'(wrap0),    32'h0);
    check("mid_rst_lap",     32'(la0),      32'h0);
    check("mid_rst_zero",    32'(zero0),    32'h1);
    apply(idle);
    check("post_rst_wrap",   32'(wrap0),    32'h0);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      in_t v;
      v.rst_n       = ($urandom_range(0, 199) != 0);
      v.clear       = ($urandom_range(0, 49) == 0);
      v.load        = ($urandom_range(0, 14) == 0);
      v.up_dn       = ($urandom_range(0, 9) < 6);
      v.tick        = ($urandom_range(0, 9) < 8);
      v.lap         = ($urandom_range(0, 19) == 0);
      v.lap_release = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 1) == 0) v.load_val = W'($urandom);
      else                            v.load_val = v.up_dn ? 24'h633B3B : 24'h000000;
      apply(v);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
